sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised synchronous FIFO, next generation of the team's 4-bit, 4-entry sync FIFO. Adds configurable width/depth, occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags. Sits between single-clock producer/consumer stages. Read data is first-word-fall-through: the head entry is always visible on `r_data`.

## Interface
- `DATA_WIDTH`, default 4: width of each entry in bits.
- `ADDR_WIDTH`, default 2: depth is DEPTH = 2**ADDR_WIDTH.
- `AF_LEVEL`, default DEPTH-1: `almost_full` asserts when count >= AF_LEVEL.
- `AE_LEVEL`, default 1: `almost_empty` asserts when count <= AE_LEVEL.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of contents and error flags.
- `wr`  in  1  write request.
- `w_data`  in  DATA_WIDTH  write data.
- `rd`  in  1  read (pop) request.
- `r_data`  out  DATA_WIDTH  head entry (FWFT); valid only when `empty`=0.
- `empty`  out  1  count == 0.
- `full`  out  1  count == DEPTH.
- `almost_empty`  out  1  count <= AE_LEVEL.
- `almost_full`  out  1  count >= AF_LEVEL.
- `count`  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a write was dropped.
- `underflow`  out  1  sticky: a read on empty was ignored.

## Operation
- Storage: DEPTH x DATA_WIDTH register array. Write and read pointers are ADDR_WIDTH bits and wrap modulo DEPTH.
- `count` is held in an explicit register of width ADDR_WIDTH+1. Flags are derived from `count`.
- Accept rules, evaluated each rising edge:
  - wr_ok = wr & (~full | rd).
  - rd_ok = rd & ~empty.
- Simultaneous events:
  - Full with rd & wr: both are accepted and count is unchanged.
  - Empty with rd & wr: the write is accepted, the read is ignored (no bypass), `underflow` sets, and count becomes 1.
- Count update: +1 on wr_ok only, -1 on rd_ok only, unchanged otherwise.
- Error flags:
  - `overflow` sets when wr & full & ~rd.
  - `underflow` sets when rd & empty.
  - Both are sticky until `flush` or reset.
- `flush` takes priority over `wr`/`rd` in the same cycle. It zeroes pointers, count and error flags. Array contents need not be cleared.
- Reset values: `count`=0, `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0 (given AF_LEVEL >= 1), `overflow`=0, `underflow`=0. `r_data` is don't-care while empty.
- Parameter legality, checked at elaboration: 1 <= AF_LEVEL <= DEPTH and 0 <= AE_LEVEL < DEPTH.

## Timing
- Write latency: data written at edge N is visible on `r_data` after edge N when the FIFO was empty. It is counted in `count`/flags after edge N.
- `r_data` = mem[rd_ptr], driven combinationally from the registered pointer. It changes only after a clock edge, never from `rd` directly.
- All flags and `count` are registered or decoded from registered state. There is no combinational path from `wr`/`rd` to any output.
- Reset acts asynchronously on assertion and is released synchronously by the environment. Reset mid-operation discards all contents within the same cycle.

## Structure
- Package `fifo_pkg`: a `clog2`-based helper for count width and a typedef for pointer width. Shared with future async/multi-channel variants.
- One sub-module, `fifo_ctrl`: pointers, count, flags and error logic, parametrised by ADDR_WIDTH/AF_LEVEL/AE_LEVEL.
- The top level holds the register array and instantiates `fifo_ctrl`.

## Test plan
All scenarios use DATA_WIDTH=4, ADDR_WIDTH=2, AF_LEVEL=3, AE_LEVEL=1.
1. Reset, then write 1,2,3,4 on consecutive cycles -> `count` goes 1,2,3,4; `almost_full` at count 3; `full`=1 after the 4th write; `r_data`=1 throughout.
2. From full, `wr` with `w_data`=5 and `rd`=0 -> data is dropped, `overflow`=1, `count`=4, `r_data` remains 1.
3. From full, `rd`=`wr`=1 with `w_data`=6 -> `count`=4, `r_data`=2. Then 4 reads -> `r_data` sequence 2,3,4,6, then `empty`=1 with no underflow.
4. On empty, `rd`=`wr`=1 with `w_data`=9 -> `count`=1, `r_data`=9, `underflow`=1.
5. Write 8 entries and read 8 interleaved, one wr/rd pair per cycle -> pointers wrap twice and data order is preserved.
6. Hold 3 entries with error flags set, then:
   - Pulse `flush` together with `wr` -> `count`=0, `empty`=1, both error flags cleared, and the write is ignored.
   - Assert `reset` low mid-stream -> all outputs reach their reset values asynchronously.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the synchronous FIFO family.
//   fifo_count_width() - width needed to hold an occupancy of 0..2**addr_width
//   fifo_ptr_t         - pointer type for the default 4-entry configuration
package fifo_pkg;

  localparam int FIFO_DEFAULT_ADDR_WIDTH = 2;

  typedef logic [FIFO_DEFAULT_ADDR_WIDTH-1:0] fifo_ptr_t;

  // Occupancy runs 0..DEPTH inclusive, so it needs one more code than DEPTH.
  function automatic int fifo_count_width(input int addr_width);
    return $clog2((1 << addr_width) + 1);
  endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy, flag and error bookkeeping for sync_fifo_param.
// Ports:
//   clk, reset (async, active-low), flush (sync clear)
//   wr, rd        - requests from producer / consumer
//   wr_en         - write strobe for the storage array (accepted, not flushed)
//   wr_ptr/rd_ptr - storage addresses, wrap modulo DEPTH
//   count         - registered occupancy 0..DEPTH
//   empty/full/almost_empty/almost_full - decoded from count
//   overflow/underflow - sticky error flags
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = fifo_count_width(ADDR_WIDTH);

  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_ctrl: AF_LEVEL must be within 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_bad_ae
    $error("fifo_ctrl: AE_LEVEL must be within 0..DEPTH-1");
  end
  if (CW != ADDR_WIDTH + 1) begin : g_bad_cw
    $error("fifo_ctrl: count width mismatch");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]         count_reg, count_next;
  logic                  overflow_reg, overflow_next;
  logic                  underflow_reg, underflow_next;
  logic                  wr_ok, rd_ok;

  assign empty        = (count_reg == '0);
  assign full         = (count_reg == CW'(DEPTH));
  assign almost_empty = (count_reg <= CW'(AE_LEVEL));
  assign almost_full  = (count_reg >= CW'(AF_LEVEL));

  // A write into a full FIFO is still taken when a pop frees the slot
  // in the same cycle; a read on empty never bypasses a concurrent write.
  assign wr_ok = wr & (~full | rd);
  assign rd_ok = rd & ~empty;
  assign wr_en = wr_ok & ~flush;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    if (flush) begin
      wr_ptr_next    = '0;
      rd_ptr_next    = '0;
      count_next     = '0;
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (rd_ok) rd_ptr_next = rd_ptr_reg + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
      if (wr & full & ~rd) overflow_next  = 1'b1;
      if (rd & empty)      underflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  assign wr_ptr    = wr_ptr_reg;
  assign rd_ptr    = rd_ptr_reg;
  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with first-word-fall-through
// read data, occupancy count, almost-full/almost-empty flags, synchronous
// flush and sticky overflow/underflow flags.
// Ports:
//   clk, reset (async, active-low), flush (sync clear)
//   wr, w_data - write request and data
//   rd         - pop request
//   r_data     - head entry, valid while empty = 0
//   empty, full, almost_empty, almost_full, count, overflow, underflow
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

  fifo_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .AF_LEVEL   (AF_LEVEL),
    .AE_LEVEL   (AE_LEVEL)
  ) u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .wr           (wr),
    .rd           (rd),
    .wr_en        (wr_en),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Storage is not reset: stale entries are unreachable once the pointers
  // and count are cleared.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (wr_en && (wr_ptr == ADDR_WIDTH'(gi))) mem_reg[gi] <= w_data;
    end
  end

  // FWFT: head entry decoded from the registered read pointer.
  assign r_data = mem_reg[rd_ptr];

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [3:0] w_data = '0;
  logic [3:0] r_data;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;
  logic [2:0] count;

  sync_fifo_param #(
    .DATA_WIDTH (4),
    .ADDR_WIDTH (2),
    .AF_LEVEL   (3),
    .AE_LEVEL   (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .wr           (wr),
    .w_data       (w_data),
    .rd           (rd),
    .r_data       (r_data),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int txn = 0;
  bit check_en = 1'b0;

  // Behavioural model: a queue of at most 4 entries plus the two sticky bits.
  logic [3:0] m_q[$];
  bit         m_ov = 1'b0;
  bit         m_un = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit w, input bit r, input bit f, input logic [3:0] d);
    bit was_full, was_empty;
    was_full  = (m_q.size() == 4);
    was_empty = (m_q.size() == 0);
    if (f) begin
      m_q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      if (w && was_full && !r) m_ov = 1'b1;
      if (r && was_empty)      m_un = 1'b1;
      if (r && !was_empty)     void'(m_q.pop_front());
      if (w && (!was_full || r)) m_q.push_back(d);
    end
  endtask

  // One clock of stimulus; inputs change 1 time unit after the rising edge.
  task automatic step(input bit w, input bit r, input bit f, input logic [3:0] d);
    wr = w; rd = r; flush = f; w_data = d;
    @(posedge clk);
    model_update(w, r, f, d);
    #1;
    wr = 1'b0; rd = 1'b0; flush = 1'b0;
    txn++;
    $display("txn %0d: wr=%0b rd=%0b flush=%0b w_data=%0d -> count=%0d r_data=%0d ovf=%0b udf=%0b",
             txn, w, r, f, d, count, r_data, overflow, underflow);
  endtask

  // Compare process: every falling edge while out of reset.
  always @(negedge clk) begin
    if (check_en) begin
      chk("count", int'(count), m_q.size());
      chk("empty", int'(empty), int'(m_q.size() == 0));
      chk("full", int'(full), int'(m_q.size() == 4));
      chk("almost_empty", int'(almost_empty), int'(m_q.size() <= 1));
      chk("almost_full", int'(almost_full), int'(m_q.size() >= 3));
      chk("overflow", int'(overflow), int'(m_ov));
      chk("underflow", int'(underflow), int'(m_un));
      if (m_q.size() != 0) chk("r_data", int'(r_data), int'(m_q[0]));
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_seq[4];
    logic [3:0] exp_wrap[9];
    exp_seq  = '{4'd2, 4'd3, 4'd4, 4'd6};
    exp_wrap = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};

    // Reset state
    #2;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_ae", int'(almost_empty), 1);
    chk("rst_af", int'(almost_full), 0);
    chk("rst_flags", int'({overflow, underflow}), 0);
    #10 reset = 1'b1;
    @(posedge clk); #1;
    check_en = 1'b1;

    // 1: fill with 1..4
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 0, 4'(i));
      chk("fill_count", int'(count), i);
      chk("fill_head", int'(r_data), 1);
      chk("fill_af", int'(almost_full), int'(i >= 3));
    end
    chk("fill_full", int'(full), 1);

    // 2: overflow drop
    step(1, 0, 0, 4'd5);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_count", int'(count), 4);
    chk("ovf_head", int'(r_data), 1);

    // 3: simultaneous rd/wr on full, then drain
    step(1, 1, 0, 4'd6);
    chk("rw_full_count", int'(count), 4);
    chk("rw_full_head", int'(r_data), 2);
    for (int i = 0; i < 4; i++) begin
      chk("drain_head", int'(r_data), int'(exp_seq[i]));
      step(0, 1, 0, 4'd0);
    end
    chk("drain_empty", int'(empty), 1);
    chk("drain_udf", int'(underflow), 0);

    // 4: simultaneous rd/wr on empty
    step(1, 1, 0, 4'd9);
    chk("rw_empty_count", int'(count), 1);
    chk("rw_empty_head", int'(r_data), 9);
    chk("rw_empty_udf", int'(underflow), 1);

    // 5: pointer wrap with interleaved traffic
    step(0, 0, 1, 4'd0);
    step(1, 0, 0, 4'd1);
    for (int i = 0; i < 8; i++) begin
      chk("wrap_head", int'(r_data), int'(exp_wrap[i]));
      step(1, 1, 0, 4'(i + 2));
      chk("wrap_count", int'(count), 1);
    end
    chk("wrap_last", int'(r_data), int'(exp_wrap[8]));
    step(0, 1, 0, 4'd0);
    chk("wrap_empty", int'(empty), 1);

    // 6: three entries with both error flags set, then flush with a write
    step(0, 1, 0, 4'd0);
    for (int i = 1; i <= 4; i++) step(1, 0, 0, 4'(i));
    step(1, 0, 0, 4'd7);
    step(0, 1, 0, 4'd0);
    chk("pre_flush_count", int'(count), 3);
    chk("pre_flush_flags", int'({overflow, underflow}), 3);
    step(1, 0, 1, 4'd5);
    chk("flush_count", int'(count), 0);
    chk("flush_empty", int'(empty), 1);
    chk("flush_flags", int'({overflow, underflow}), 0);

    // Async reset mid-stream
    step(1, 0, 0, 4'd11);
    step(1, 0, 0, 4'd12);
    step(0, 0, 0, 4'd0);
    #1;
    check_en = 1'b0;
    reset = 1'b0;
    m_q.delete();
    m_ov = 1'b0;
    m_un = 1'b0;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_empty", int'(empty), 1);
    chk("arst_full", int'(full), 0);
    chk("arst_ae", int'(almost_empty), 1);
    chk("arst_af", int'(almost_full), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_en = 1'b1;
    step(1, 0, 0, 4'd3);
    chk("post_rst_count", int'(count), 1);
    chk("post_rst_head", int'(r_data), 3);
    @(negedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
